// File: rtl/slap_video_pkg.sv
// rtl/slap_video_pkg.sv - shared widths, layer codes and helpers for the video mixer
package slap_video_pkg;

    localparam int PIX_W     = 8;
    localparam int COL_W     = 4;
    localparam int PAL_DEPTH = 256;
    localparam int PAL_AW    = $clog2(PAL_DEPTH);

    typedef enum logic [1:0] {
        LYR_NONE = 2'd0,
        LYR_BG   = 2'd1,
        LYR_SPR  = 2'd2,
        LYR_FG   = 2'd3
    } layer_t;

    // A layer pixel is opaque when its colour nibble is non-zero.
    function automatic logic is_opaque(input logic [PIX_W-1:0] pix);
        return pix[COL_W-1:0] != '0;
    endfunction

endpackage

// File: rtl/slap_colour_prom.sv
// rtl/slap_colour_prom.sv - 256x4 colour PROM image, sync download write and sync read
module slap_colour_prom
    import slap_video_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PAL_AW-1:0] wr_addr,
    input  logic [COL_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [PAL_AW-1:0] rd_addr,
    output logic [COL_W-1:0]  rd_data
);

    // Contents survive reset; only a download changes them.
    logic [COL_W-1:0] mem [PAL_DEPTH];

    // Read-before-write: a same-cycle read of the written entry returns the old value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/slap_video_mixer.sv
// rtl/slap_video_mixer.sv - FG/sprite/BG priority mix, colour PROM lookup, registered RGB
module slap_video_mixer
    import slap_video_pkg::*;
#(
    parameter logic [PIX_W-1:0] FG_BASE  = 8'h00,
    parameter logic [PIX_W-1:0] SPR_BASE = 8'h80,
    parameter logic [PIX_W-1:0] BG_BASE  = 8'h00
) (
    input  logic              master_clk,
    input  logic              nRESET,
    input  logic              pixel_ce,
    input  logic [PIX_W-1:0]  FG_PIX,
    input  logic [PIX_W-1:0]  SPR_PIX,
    input  logic [PIX_W-1:0]  BG_PIX,
    input  logic              HBLANK,
    input  logic              VBLANK,
    input  logic [2:0]        LAYER_EN,
    input  logic [24:0]       dn_addr,
    input  logic [7:0]        dn_data,
    input  logic              dn_wr,
    input  logic              prom_r_cs,
    input  logic              prom_g_cs,
    input  logic              prom_b_cs,
    output logic [COL_W-1:0]  RED,
    output logic [COL_W-1:0]  GREEN,
    output logic [COL_W-1:0]  BLUE,
    output logic              HBLANK_o,
    output logic              VBLANK_o
);

    layer_t           win_lyr;
    logic [PIX_W-1:0] win_idx;

    // Stage 1 registers
    logic [PIX_W-1:0] s1_idx;
    logic             s1_blank, s1_hb, s1_vb, s1_vld;
    // Stage 2 registers (aligned with the PROM read data)
    logic             s2_blank, s2_hb, s2_vb, s2_vld;

    logic [COL_W-1:0] prom_r, prom_g, prom_b;

    // Upper download address bits and data nibble carry no meaning here.
    logic unused_dn;
    assign unused_dn = ^{dn_addr[24:8], dn_data[7:4]};

    // Fixed priority: FG over sprite over BG; disabled layers count as transparent.
    always_comb begin
        win_lyr = LYR_NONE;
        if (LAYER_EN[2] && is_opaque(FG_PIX)) begin
            win_lyr = LYR_FG;
        end else if (LAYER_EN[1] && is_opaque(SPR_PIX)) begin
            win_lyr = LYR_SPR;
        end else if (LAYER_EN[0]) begin
            win_lyr = LYR_BG;
        end
    end

    // Palette bank select is a plain OR, so the index always stays within 8 bits.
    always_comb begin
        win_idx = '0;
        case (win_lyr)
            LYR_FG:  win_idx = FG_PIX  | FG_BASE;
            LYR_SPR: win_idx = SPR_PIX | SPR_BASE;
            LYR_BG:  win_idx = BG_PIX  | BG_BASE;
            default: win_idx = '0;
        endcase
    end

    // Stage 1: capture the winning index and blanking; valid marks real pixels after reset.
    always_ff @(posedge master_clk or negedge nRESET) begin
        if (!nRESET) begin
            s1_idx   <= '0;
            s1_blank <= 1'b0;
            s1_hb    <= 1'b0;
            s1_vb    <= 1'b0;
            s1_vld   <= 1'b0;
        end else if (pixel_ce) begin
            s1_idx   <= win_idx;
            s1_blank <= HBLANK | VBLANK;
            s1_hb    <= HBLANK;
            s1_vb    <= VBLANK;
            s1_vld   <= 1'b1;
        end
    end

    // Stage 2: carry side-band alongside the PROM read launched on the same strobe.
    always_ff @(posedge master_clk or negedge nRESET) begin
        if (!nRESET) begin
            s2_blank <= 1'b0;
            s2_hb    <= 1'b0;
            s2_vb    <= 1'b0;
            s2_vld   <= 1'b0;
        end else if (pixel_ce) begin
            s2_blank <= s1_blank;
            s2_hb    <= s1_hb;
            s2_vb    <= s1_vb;
            s2_vld   <= s1_vld;
        end
    end

    // Stage 3: drive RGB; blanked or pre-reset-flush pixels are forced black.
    always_ff @(posedge master_clk or negedge nRESET) begin
        if (!nRESET) begin
            RED      <= '0;
            GREEN    <= '0;
            BLUE     <= '0;
            HBLANK_o <= 1'b0;
            VBLANK_o <= 1'b0;
        end else if (pixel_ce) begin
            if (s2_blank || !s2_vld) begin
                RED   <= '0;
                GREEN <= '0;
                BLUE  <= '0;
            end else begin
                RED   <= prom_r;
                GREEN <= prom_g;
                BLUE  <= prom_b;
            end
            HBLANK_o <= s2_hb;
            VBLANK_o <= s2_vb;
        end
    end

    slap_colour_prom u_prom_r (
        .clk     (master_clk),
        .wr_en   (dn_wr & prom_r_cs),
        .wr_addr (dn_addr[PAL_AW-1:0]),
        .wr_data (dn_data[COL_W-1:0]),
        .rd_en   (pixel_ce),
        .rd_addr (s1_idx),
        .rd_data (prom_r)
    );

    slap_colour_prom u_prom_g (
        .clk     (master_clk),
        .wr_en   (dn_wr & prom_g_cs),
        .wr_addr (dn_addr[PAL_AW-1:0]),
        .wr_data (dn_data[COL_W-1:0]),
        .rd_en   (pixel_ce),
        .rd_addr (s1_idx),
        .rd_data (prom_g)
    );

    slap_colour_prom u_prom_b (
        .clk     (master_clk),
        .wr_en   (dn_wr & prom_b_cs),
        .wr_addr (dn_addr[PAL_AW-1:0]),
        .wr_data (dn_data[COL_W-1:0]),
        .rd_en   (pixel_ce),
        .rd_addr (s1_idx),
        .rd_data (prom_b)
    );

endmodule
